// File: rtl/lr35902_joy_matrix.sv
`default_nettype none
// ============================================================================
// Module      : lr35902_joy_matrix
// Description : Joypad front end for the P1/FF00 register. Synchronises and
//               debounces the eight raw button pins, then emulates the DMG
//               2x4 key matrix driving p10..p13 (active-low) according to the
//               p14 (directions) / p15 (buttons) select lines.
// Ports       : clk      - system clock
//               reset    - synchronous, active-high reset
//               btn_n    - raw pins, active-low, asynchronous
//                          [0]Right [1]Left [2]Up [3]Down
//                          [4]A [5]B [6]Select [7]Start
//               p14/p15  - direction / button group select, active-low
//               p10..p13 - matrix lines, active-low, registered
//               pressed  - debounced state, active-high, btn_n bit order
// Revision    : 1.0 - initial release
// ============================================================================
module lr35902_joy_matrix #(
   parameter int DEB_CYCLES    = 4096,
   parameter bit MASK_OPPOSITE = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] btn_n,
   input  logic       p14,
   input  logic       p15,
   output logic       p10,
   output logic       p11,
   output logic       p12,
   output logic       p13,
   output logic [7:0] pressed
);

   localparam logic [15:0] C_LAST = 16'(DEB_CYCLES - 1);

   logic [7:0] r_s1;
   logic [7:0] r_s2;
   logic [7:0] w_stable;
   logic [3:0] w_dir_eff;
   logic [3:0] r_p1;

   // Two-flop synchroniser; reset to "released".
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1 <= 8'hFF;
         r_s2 <= 8'hFF;
      end else begin
         r_s1 <= btn_n;
         r_s2 <= r_s1;
      end
   end

   // Per-pin debouncer: a new level must be seen DEB_CYCLES consecutive
   // cycles at the synchroniser output. Any return to the accepted level
   // restarts the count, so the counter never exceeds C_LAST.
   for (genvar i = 0; i < 8; i++) begin : g_deb
      logic        r_bit;
      logic [15:0] r_cnt;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_bit <= 1'b1;
            r_cnt <= 16'd0;
         end else if (r_s2[i] == r_bit) begin
            r_cnt <= 16'd0;
         end else if (r_cnt == C_LAST) begin
            r_bit <= r_s2[i];
            r_cnt <= 16'd0;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
      end

      assign w_stable[i] = r_bit;
   end

   assign pressed = ~w_stable;

   // Physically impossible opposite-direction pairs are reported as neither
   // key pressed on the matrix; the debug vector is left untouched.
   if (MASK_OPPOSITE) begin : g_mask
      assign w_dir_eff[0] = pressed[0] & ~pressed[1];
      assign w_dir_eff[1] = pressed[1] & ~pressed[0];
      assign w_dir_eff[2] = pressed[2] & ~pressed[3];
      assign w_dir_eff[3] = pressed[3] & ~pressed[2];
   end else begin : g_nomask
      assign w_dir_eff = pressed[3:0];
   end

   // Matrix lines: with both groups selected the result is the wired-AND of
   // the two groups. Selects come from the same clock domain.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_p1 <= 4'hF;
      end else begin
         for (int n = 0; n < 4; n++) begin
            r_p1[n] <= ~((~p14 & w_dir_eff[n]) | (~p15 & pressed[n+4]));
         end
      end
   end

   assign p10 = r_p1[0];
   assign p11 = r_p1[1];
   assign p12 = r_p1[2];
   assign p13 = r_p1[3];

endmodule
`default_nettype wire

// File: tb/tb_lr35902_joy_matrix.sv
`default_nettype none
// ============================================================================
// Module      : tb_lr35902_joy_matrix
// Description : Self-checking bench for lr35902_joy_matrix. Three instances
//               (DEB 4 masked, DEB 4 unmasked, DEB 1 masked) share stimulus
//               and are compared each cycle against a run-length model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lr35902_joy_matrix;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] btn_n = 8'hFF;
   logic       p14 = 1'b1;
   logic       p15 = 1'b1;

   wire [7:0] pr_a, pr_b, pr_c;
   wire [3:0] pl_a, pl_b, pl_c;

   int tests = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lr35902_joy_matrix #(.DEB_CYCLES(4), .MASK_OPPOSITE(1'b1)) dut_a (
      .clk(clk), .reset(reset), .btn_n(btn_n), .p14(p14), .p15(p15),
      .p10(pl_a[0]), .p11(pl_a[1]), .p12(pl_a[2]), .p13(pl_a[3]),
      .pressed(pr_a));

   lr35902_joy_matrix #(.DEB_CYCLES(4), .MASK_OPPOSITE(1'b0)) dut_b (
      .clk(clk), .reset(reset), .btn_n(btn_n), .p14(p14), .p15(p15),
      .p10(pl_b[0]), .p11(pl_b[1]), .p12(pl_b[2]), .p13(pl_b[3]),
      .pressed(pr_b));

   lr35902_joy_matrix #(.DEB_CYCLES(1), .MASK_OPPOSITE(1'b1)) dut_c (
      .clk(clk), .reset(reset), .btn_n(btn_n), .p14(p14), .p15(p15),
      .p10(pl_c[0]), .p11(pl_c[1]), .p12(pl_c[2]), .p13(pl_c[3]),
      .pressed(pr_c));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: a pin level is accepted once the synchronised value
   // has held the same level for DEB consecutive samples while differing
   // from the accepted level. Matrix is a truth-table of the select lines.
   // ------------------------------------------------------------------------
   int         c_deb[3]  = '{4, 4, 1};
   bit         c_mask[3] = '{1'b1, 1'b0, 1'b1};
   logic [7:0] m_pipe1[3], m_pipe2[3], m_acc[3];
   logic [3:0] m_lines[3];
   logic       m_last[3][8];
   int         m_run[3][8];
   bit         m_valid = 1'b0;

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            m_pipe1[k] = 8'hFF;
            m_pipe2[k] = 8'hFF;
            m_acc[k]   = 8'hFF;
            m_lines[k] = 4'hF;
            for (int i = 0; i < 8; i++) begin
               m_last[k][i] = 1'b1;
               m_run[k][i]  = 0;
            end
         end else begin
            logic [7:0] held;
            logic [3:0] dir;
            held = ~m_acc[k];
            dir  = held[3:0];
            if (c_mask[k]) begin
               if (held[0] && held[1]) dir[1:0] = 2'b00;
               if (held[2] && held[3]) dir[3:2] = 2'b00;
            end
            for (int n = 0; n < 4; n++) begin
               m_lines[k][n] = !((!p14 && dir[n]) || (!p15 && held[n+4]));
            end
            for (int i = 0; i < 8; i++) begin
               logic x;
               x = m_pipe2[k][i];
               if (x == m_last[k][i]) m_run[k][i]++;
               else m_run[k][i] = 1;
               m_last[k][i] = x;
               if (x != m_acc[k][i] && m_run[k][i] >= c_deb[k]) m_acc[k][i] = x;
            end
            m_pipe2[k] = m_pipe1[k];
            m_pipe1[k] = btn_n;
         end
      end
      if (reset) m_valid = 1'b1;
   end

   // Per-cycle comparison of every instance against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         check("model pressed a", {24'd0, pr_a}, {24'd0, ~m_acc[0]});
         check("model lines a",   {28'd0, pl_a}, {28'd0, m_lines[0]});
         check("model pressed b", {24'd0, pr_b}, {24'd0, ~m_acc[1]});
         check("model lines b",   {28'd0, pl_b}, {28'd0, m_lines[1]});
         check("model pressed c", {24'd0, pr_c}, {24'd0, ~m_acc[2]});
         check("model lines c",   {28'd0, pl_c}, {28'd0, m_lines[2]});
      end
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      edges(3);
      check("reset pressed", {24'd0, pr_a}, 32'h00);
      check("reset lines",   {28'd0, pl_a}, 32'hF);
      reset = 1'b0;

      // Right press, direction group selected.
      btn_n = 8'hFE; p14 = 1'b0; p15 = 1'b1;
      edges(5);
      check("press edge4 a",  {24'd0, pr_a}, 32'h00);
      check("press deb1 c",   {24'd0, pr_c}, 32'h01);
      check("p10 deb1 c",     {31'd0, pl_c[0]}, 32'h0);
      edges(1);
      check("press edge5 a",  {24'd0, pr_a}, 32'h01);
      check("p10 edge5 a",    {28'd0, pl_a}, 32'hF);
      edges(1);
      check("p10 edge6 a",    {28'd0, pl_a}, 32'hE);

      // Short A glitch is rejected, longer hold is accepted.
      btn_n = 8'hEE;
      edges(3);
      btn_n = 8'hFE;
      for (int j = 0; j < 10; j++) begin
         check("glitch A", {24'd0, pr_a}, 32'h01);
         edges(1);
      end
      btn_n = 8'hEE;
      edges(6);
      check("A accepted", {24'd0, pr_a}, 32'h11);

      // Select sweep with A and Right held.
      p15 = 1'b1; p14 = 1'b1;
      #1 check("sweep 11 before edge", {31'd0, pl_a[0]}, 32'h0);
      edges(1);
      check("sweep 11", {31'd0, pl_a[0]}, 32'h1);
      p15 = 1'b1; p14 = 1'b0; edges(1);
      check("sweep 10", {31'd0, pl_a[0]}, 32'h0);
      p15 = 1'b0; p14 = 1'b1; edges(1);
      check("sweep 01", {31'd0, pl_a[0]}, 32'h0);
      p15 = 1'b0; p14 = 1'b0; edges(1);
      check("sweep 00", {28'd0, pl_a}, 32'hE);

      // Opposite directions.
      btn_n = 8'hFF; p14 = 1'b0; p15 = 1'b1;
      edges(10);
      btn_n = 8'hFC;
      edges(8);
      check("LR pressed",    {24'd0, pr_a}, 32'h03);
      check("LR masked",     {30'd0, pl_a[1:0]}, 32'h3);
      check("LR unmasked",   {30'd0, pl_b[1:0]}, 32'h0);
      btn_n = 8'hFD;
      edges(8);
      check("L only masked", {30'd0, pl_a[1:0]}, 32'h1);

      // Reset while Start is held.
      btn_n = 8'h7F; p14 = 1'b1; p15 = 1'b0;
      edges(8);
      check("start p13", {31'd0, pl_a[3]}, 32'h0);
      reset = 1'b1;
      edges(1);
      check("rst lines",   {28'd0, pl_a}, 32'hF);
      check("rst pressed", {24'd0, pr_a}, 32'h00);
      reset = 1'b0;
      edges(4);
      check("requalify early", {24'd0, pr_a}, 32'h00);
      edges(4);
      check("requalify done",  {24'd0, pr_a}, 32'h80);

      // Bouncy release of Up.
      btn_n = 8'hFB; p14 = 1'b0; p15 = 1'b1;
      edges(8);
      check("up held", {24'd0, pr_a}, 32'h04);
      btn_n = 8'hFF; edges(2);
      btn_n = 8'hFB; edges(2);
      btn_n = 8'hFF;
      edges(5);
      check("bounce not yet", {31'd0, pr_a[2]}, 32'h1);
      edges(1);
      check("bounce cleared", {31'd0, pr_a[2]}, 32'h0);

      // Randomised phase checked by the model.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 11) == 0) btn_n[i] = ~btn_n[i];
         end
         {p15, p14} = 2'($urandom);
         reset = ($urandom_range(0, 399) == 0);
         edges(1);
      end
      reset = 1'b0;
      edges(2);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
`default_nettype wire
